ph_pwm_multi: RTL

Parametrised N-channel phase PWM generator; next generation of the fixed 3-phase simple PWM block.
One shared period counter drives NCH channels, each with its own duty and phase offset.
Period, duty and phase are double-buffered; updates commit only at a period boundary, so no glitches occur.
ENABLE deassertion drains the current period before stopping; the block sits between the control register file and the phase drivers.

---
 rtl/ph_pwm_pkg.sv | 26 ++
 rtl/ph_pwm_chan.sv | 36 +++
 rtl/ph_pwm_multi.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ph_pwm_pkg.sv
// Shared definitions for the multi-channel phase PWM: state encoding,
// reset defaults and the commit-time clamp helpers.
package ph_pwm_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

  localparam int PKG_NCH        = 3;
  localparam int PKG_CW         = 16;
  localparam int PKG_DEF_PERIOD = 1000;
  localparam int PKG_DEF_DUTY   = 500;
  localparam int MIN_PERIOD     = 2;

  // Values are carried in 32 bits so one helper serves any CW up to 32.
  function automatic logic [31:0] clamp_per(input logic [31:0] per);
    return (per < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : per;
  endfunction

  function automatic logic [31:0] clamp_phase(input logic [31:0] phase, input logic [31:0] per);
    return (phase >= per) ? 32'd0 : phase;
  endfunction

endpackage

// File: rtl/ph_pwm_chan.sv
// One PWM channel: shifts the shared counter by this channel's phase,
// wraps it into the period and registers the duty compare.
module ph_pwm_chan #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] per,
  input  logic [CW-1:0] duty,
  input  logic [CW-1:0] phase,
  input  logic          run,
  output logic          pwm
);

  logic [CW:0] sum;
  logic [CW:0] loc;
  logic        pwm_reg;

  // One extra bit so cnt + phase cannot overflow before the wrap.
  always_comb begin
    sum = {1'b0, cnt} + {1'b0, phase};
    loc = (sum >= {1'b0, per}) ? (sum - {1'b0, per}) : sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_reg <= 1'b0;
    end else begin
      pwm_reg <= run && (loc < {1'b0, duty});
    end
  end

  assign pwm = pwm_reg;

endmodule

// File: rtl/ph_pwm_multi.sv
// N-channel phase PWM: one shared period counter, double-buffered
// period/duty/phase that commit only at a period boundary, drain on disable.
module ph_pwm_multi
  import ph_pwm_pkg::*;
#(
  parameter int NCH        = PKG_NCH,
  parameter int CW         = PKG_CW,
  parameter int DEF_PERIOD = PKG_DEF_PERIOD,
  parameter int DEF_DUTY   = PKG_DEF_DUTY
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              ENABLE,
  input  logic              LOAD,
  input  logic [CW-1:0]     PERIOD,
  input  logic [NCH*CW-1:0] DUTY,
  input  logic [NCH*CW-1:0] PHASE,
  output logic [NCH-1:0]    PWM,
  output logic              PERIOD_START,
  output logic              LOAD_PEND,
  output logic              BUSY
);

  localparam logic [CW-1:0]     DEF_PER_W  = CW'(DEF_PERIOD);
  localparam logic [CW-1:0]     DEF_DUTY_1 = CW'(DEF_DUTY);
  localparam logic [NCH*CW-1:0] DEF_DUTY_W = {NCH{DEF_DUTY_1}};

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [CW-1:0]       per_reg, per_sh_reg, per_commit;
  logic [NCH*CW-1:0]   duty_reg, duty_sh_reg;
  logic [NCH*CW-1:0]   phase_reg, phase_sh_reg, phase_commit;
  logic                load_pend_reg, period_start_reg, busy_reg;
  logic                wrap, commit, run;

  assign wrap   = (cnt_reg == per_reg - CW'(1));
  assign run    = (state_reg != ST_IDLE);
  assign commit = load_pend_reg && (!run || wrap);

  // Phase is clamped against the period being committed alongside it.
  assign per_commit = CW'(clamp_per(32'(per_sh_reg)));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (ENABLE) state_next = ST_RUN;
      end
      ST_RUN: begin
        cnt_next = wrap ? '0 : cnt_reg + CW'(1);
        if (!ENABLE) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        cnt_next = wrap ? '0 : cnt_reg + CW'(1);
        if (ENABLE)    state_next = ST_RUN;
        else if (wrap) state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      per_reg          <= DEF_PER_W;
      duty_reg         <= DEF_DUTY_W;
      phase_reg        <= '0;
      per_sh_reg       <= DEF_PER_W;
      duty_sh_reg      <= DEF_DUTY_W;
      phase_sh_reg     <= '0;
      load_pend_reg    <= 1'b0;
      period_start_reg <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      period_start_reg <= (state_next != ST_IDLE) && (cnt_next == '0);
      busy_reg         <= (state_next != ST_IDLE);
      // Commit reads the old shadow, so a LOAD on the wrap edge waits a period.
      if (commit) begin
        per_reg   <= per_commit;
        duty_reg  <= duty_sh_reg;
        phase_reg <= phase_commit;
      end
      if (LOAD) begin
        per_sh_reg   <= PERIOD;
        duty_sh_reg  <= DUTY;
        phase_sh_reg <= PHASE;
      end
      load_pend_reg <= LOAD || (load_pend_reg && !commit);
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign phase_commit[gi*CW +: CW] =
      CW'(clamp_phase(32'(phase_sh_reg[gi*CW +: CW]), 32'(per_commit)));

    ph_pwm_chan #(.CW(CW)) u_chan (
      .clk   (CLK),
      .rst_n (RESET_N),
      .cnt   (cnt_reg),
      .per   (per_reg),
      .duty  (duty_reg[gi*CW +: CW]),
      .phase (phase_reg[gi*CW +: CW]),
      .run   (run),
      .pwm   (PWM[gi])
    );
  end

  assign PERIOD_START = period_start_reg;
  assign LOAD_PEND    = load_pend_reg;
  assign BUSY         = busy_reg;

endmodule
